// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus responder: FSM states, bus-cycle classes
// and the default open-bus byte.
package z80_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        MEM,
        IO,
        INTACK
    } cycle_t;

    localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hFF;

    function automatic logic is_backend_cycle(cycle_t cyc);
        return (cyc == MEM) || (cyc == IO);
    endfunction

endpackage

// File: rtl/z80_bus_responder_if.sv
// CPU strobe/data bus, interrupt lines and backend req/ack channel of the
// responder. The slave modport is the responder's view.
interface z80_bus_responder_if;

    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic        rfsh_n;
    logic [15:0] A;
    logic [7:0]  cpu_dout;
    logic [7:0]  di;
    logic        wait_n;
    logic        int_n;
    logic        int_req;
    logic [7:0]  int_vector;
    logic        be_req;
    logic        be_we;
    logic        be_io;
    logic [15:0] be_addr;
    logic [7:0]  be_wdata;
    logic        be_ack;
    logic [7:0]  be_rdata;
    logic        protocol_err;

    modport slave (
        input  mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, A, cpu_dout,
        input  int_req, int_vector, be_ack, be_rdata,
        output di, wait_n, int_n, be_req, be_we, be_io, be_addr, be_wdata,
        output protocol_err
    );

    modport master (
        output mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, A, cpu_dout,
        output int_req, int_vector, be_ack, be_rdata,
        input  di, wait_n, int_n, be_req, be_we, be_io, be_addr, be_wdata,
        input  protocol_err
    );

endinterface

// File: rtl/z80_cycle_decode.sv
// Combinational classification of the current Z80 strobe pattern into a
// bus-cycle type, plus write direction and the read+write conflict term.
module z80_cycle_decode
    import z80_bus_pkg::*;
(
    input  logic   mreq_n,
    input  logic   iorq_n,
    input  logic   rd_n,
    input  logic   wr_n,
    input  logic   m1_n,
    input  logic   rfsh_n,
    output cycle_t cyc,
    output logic   is_write,
    output logic   proto_err
);

    logic data_strobe;

    assign data_strobe = ~rd_n | ~wr_n;
    // A simultaneous read and write is resolved as a write.
    assign is_write    = ~wr_n;
    assign proto_err   = ~rd_n & ~wr_n;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cyc = NONE;
        if (!m1_n && !iorq_n)
            cyc = INTACK;
        else if (!iorq_n && data_strobe)
            cyc = IO;
        else if (!mreq_n && rfsh_n && data_strobe)
            cyc = MEM;
    end

endmodule

// File: rtl/z80_bus_responder.sv
// Target-side Z80 bus responder: forwards memory/I/O cycles to a req/ack
// backend, stretches them with wait_n and answers interrupt-acknowledge.
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter int         WAIT_STATES = 0,
    parameter int         IO_WAIT     = 1,
    parameter logic [7:0] OPEN_BUS    = OPEN_BUS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    z80_bus_responder_if.slave  bus
);

    localparam int CNT_W = $clog2(WAIT_STATES + IO_WAIT + 2);
    localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] IO_LOAD  = CNT_W'(WAIT_STATES + IO_WAIT);

    cycle_t            cyc;
    logic              is_write;
    logic              proto_err;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  cnt_dec;
    logic              ack_seen;
    logic              ack_now;
    logic              int_pending;
    logic              pending_nxt;
    logic              start_access;
    logic              start_intack;
    logic              strobes_idle;

    logic [7:0]        di_q;
    logic              int_n_q;
    logic              be_req_q;
    logic              be_we_q;
    logic              be_io_q;
    logic [15:0]       be_addr_q;
    logic [7:0]        be_wdata_q;
    logic              perr_q;

    z80_cycle_decode u_decode (
        .mreq_n    (bus.mreq_n),
        .iorq_n    (bus.iorq_n),
        .rd_n      (bus.rd_n),
        .wr_n      (bus.wr_n),
        .m1_n      (bus.m1_n),
        .rfsh_n    (bus.rfsh_n),
        .cyc       (cyc),
        .is_write  (is_write),
        .proto_err (proto_err)
    );

    assign start_access = (state == IDLE) && is_backend_cycle(cyc);
    assign start_intack = (state == IDLE) && (cyc == INTACK);
    assign strobes_idle = bus.mreq_n && bus.iorq_n && bus.rd_n && bus.wr_n;
    // Acks only count while a request is outstanding; strays are dropped.
    assign ack_now      = be_req_q && bus.be_ack;
    assign cnt_dec      = (wait_cnt == '0) ? '0 : wait_cnt - CNT_W'(1);
    assign pending_nxt  = bus.int_req || (int_pending && !start_intack);

    assign bus.wait_n       = !((state == ACCESS) || start_access);
    assign bus.di           = di_q;
    assign bus.int_n        = int_n_q;
    assign bus.be_req       = be_req_q;
    assign bus.be_we        = be_we_q;
    assign bus.be_io        = be_io_q;
    assign bus.be_addr      = be_addr_q;
    assign bus.be_wdata     = be_wdata_q;
    assign bus.protocol_err = perr_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            ack_seen    <= 1'b0;
            int_pending <= 1'b0;
            di_q        <= OPEN_BUS;
            int_n_q     <= 1'b1;
            be_req_q    <= 1'b0;
            be_we_q     <= 1'b0;
            be_io_q     <= 1'b0;
            be_addr_q   <= '0;
            be_wdata_q  <= '0;
            perr_q      <= 1'b0;
        end else begin
            int_pending <= pending_nxt;
            int_n_q     <= !pending_nxt;

            case (state)
                IDLE: begin
                    if (start_access) begin
                        state      <= ACCESS;
                        be_req_q   <= 1'b1;
                        be_we_q    <= is_write;
                        be_io_q    <= (cyc == IO);
                        be_addr_q  <= bus.A;
                        be_wdata_q <= bus.cpu_dout;
                        wait_cnt   <= (cyc == IO) ? IO_LOAD : MEM_LOAD;
                        ack_seen   <= 1'b0;
                        if (proto_err)
                            perr_q <= 1'b1;
                    end else if (start_intack) begin
                        state <= HOLD;
                        di_q  <= bus.int_vector;
                    end
                end

                ACCESS: begin
                    wait_cnt <= cnt_dec;
                    if (ack_now) begin
                        be_req_q <= 1'b0;
                        ack_seen <= 1'b1;
                        if (!be_we_q)
                            di_q <= bus.be_rdata;
                    end
                    // Leave once the post-decrement count is exhausted, so the
                    // ACCESS cycle itself counts as one of the minimum waits.
                    if ((ack_seen || ack_now) && cnt_dec == '0)
                        state <= HOLD;
                end

                HOLD: begin
                    if (strobes_idle) begin
                        state <= IDLE;
                        di_q  <= OPEN_BUS;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed self-checking bench for z80_bus_responder (WAIT_STATES=0,
// IO_WAIT=1, OPEN_BUS=8'hFF).
module tb_z80_bus_responder;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   req_rises;
    int   req_mark;
    logic req_prev;

    z80_bus_responder_if bus ();

    z80_bus_responder #(
        .WAIT_STATES (0),
        .IO_WAIT     (1),
        .OPEN_BUS    (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts distinct backend requests (rising edges of be_req).
    initial begin
        req_rises = 0;
        req_prev  = 1'b0;
    end
    always @(posedge clk) begin
        if (bus.be_req && !req_prev)
            req_rises <= req_rises + 1;
        req_prev <= bus.be_req;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic bus_idle();
        bus.mreq_n  = 1'b1;
        bus.iorq_n  = 1'b1;
        bus.rd_n    = 1'b1;
        bus.wr_n    = 1'b1;
        bus.m1_n    = 1'b1;
        bus.rfsh_n  = 1'b1;
        bus.be_ack  = 1'b0;
        bus.int_req = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus_idle();
        bus.A          = 16'h0000;
        bus.cpu_dout   = 8'h00;
        bus.int_vector = 8'h00;
        bus.be_rdata   = 8'h00;
        reset          = 1'b1;
        tick();
        tick();

        check("rst_di",       bus.di,           8'hFF);
        check("rst_wait_n",   bus.wait_n,       1'b1);
        check("rst_int_n",    bus.int_n,        1'b1);
        check("rst_be_req",   bus.be_req,       1'b0);
        check("rst_be_we",    bus.be_we,        1'b0);
        check("rst_be_io",    bus.be_io,        1'b0);
        check("rst_be_addr",  bus.be_addr,      16'h0000);
        check("rst_be_wdata", bus.be_wdata,     8'h00);
        check("rst_perr",     bus.protocol_err, 1'b0);
        reset = 1'b0;
        tick();

        // Memory read, ack in the third ACCESS cycle.
        req_mark = req_rises;
        bus.A      = 16'h1234;
        bus.mreq_n = 1'b0;
        bus.rd_n   = 1'b0;
        settle();
        check("mrd_detect_wait", bus.wait_n, 1'b0);
        check("mrd_detect_req",  bus.be_req, 1'b0);
        tick();
        check("mrd_req",    bus.be_req,  1'b1);
        check("mrd_addr",   bus.be_addr, 16'h1234);
        check("mrd_we",     bus.be_we,   1'b0);
        check("mrd_io",     bus.be_io,   1'b0);
        check("mrd_wait1",  bus.wait_n,  1'b0);
        tick();
        check("mrd_wait2",  bus.wait_n,  1'b0);
        check("mrd_req2",   bus.be_req,  1'b1);
        tick();
        bus.be_ack   = 1'b1;
        bus.be_rdata = 8'h5A;
        settle();
        check("mrd_wait3",  bus.wait_n,  1'b0);
        tick();
        bus.be_ack   = 1'b0;
        bus.be_rdata = 8'h00;
        settle();
        check("mrd_wait_rel", bus.wait_n, 1'b1);
        check("mrd_req_drop", bus.be_req, 1'b0);
        check("mrd_di",       bus.di,     8'h5A);
        tick();
        check("mrd_di_hold",  bus.di,     8'h5A);
        bus.mreq_n = 1'b1;
        bus.rd_n   = 1'b1;
        tick();
        check("mrd_di_open",  bus.di,     8'hFF);
        check("mrd_one_req",  req_rises - req_mark, 1);

        // I/O write with an immediate ack.
        bus.A        = 16'h00FE;
        bus.cpu_dout = 8'h3C;
        bus.iorq_n   = 1'b0;
        bus.wr_n     = 1'b0;
        settle();
        check("iow_detect_wait", bus.wait_n, 1'b0);
        tick();
        bus.be_ack = 1'b1;
        settle();
        check("iow_io",    bus.be_io,    1'b1);
        check("iow_we",    bus.be_we,    1'b1);
        check("iow_wdata", bus.be_wdata, 8'h3C);
        check("iow_addr",  bus.be_addr,  16'h00FE);
        check("iow_wait1", bus.wait_n,   1'b0);
        tick();
        bus.be_ack = 1'b0;
        settle();
        check("iow_wait_rel", bus.wait_n, 1'b1);
        check("iow_req_drop", bus.be_req, 1'b0);
        check("iow_di_open",  bus.di,     8'hFF);
        bus.iorq_n = 1'b1;
        bus.wr_n   = 1'b1;
        tick();

        // Interrupt: pulse, then an ack that coincides with a fresh pulse.
        req_mark = req_rises;
        check("int_idle", bus.int_n, 1'b1);
        bus.int_req = 1'b1;
        tick();
        bus.int_req = 1'b0;
        settle();
        check("int_raised", bus.int_n, 1'b0);
        bus.int_vector = 8'hD7;
        bus.m1_n       = 1'b0;
        bus.iorq_n     = 1'b0;
        bus.int_req    = 1'b1;
        settle();
        check("ack1_no_wait", bus.wait_n, 1'b1);
        tick();
        bus.int_req = 1'b0;
        settle();
        check("ack1_di",       bus.di,     8'hD7);
        check("ack1_set_wins", bus.int_n,  1'b0);
        check("ack1_wait",     bus.wait_n, 1'b1);
        bus.m1_n   = 1'b1;
        bus.iorq_n = 1'b1;
        tick();
        check("ack1_di_open",  bus.di,     8'hFF);
        bus.int_vector = 8'hFF;
        bus.m1_n       = 1'b0;
        bus.iorq_n     = 1'b0;
        settle();
        check("ack2_no_wait", bus.wait_n, 1'b1);
        tick();
        check("ack2_di",      bus.di,     8'hFF);
        check("ack2_int_n",   bus.int_n,  1'b1);
        check("ack2_wait",    bus.wait_n, 1'b1);
        bus.m1_n   = 1'b1;
        bus.iorq_n = 1'b1;
        tick();
        check("int_no_req",   req_rises - req_mark, 0);

        // Refresh is ignored; the following read makes exactly one request.
        req_mark = req_rises;
        bus.A      = 16'h0042;
        bus.mreq_n = 1'b0;
        bus.rfsh_n = 1'b0;
        settle();
        check("rfsh_no_wait", bus.wait_n, 1'b1);
        tick();
        check("rfsh_no_req1", bus.be_req, 1'b0);
        tick();
        check("rfsh_no_req2", bus.be_req, 1'b0);
        bus.rfsh_n = 1'b1;
        bus.rd_n   = 1'b0;
        bus.A      = 16'h0043;
        settle();
        check("rfrd_detect_wait", bus.wait_n, 1'b0);
        tick();
        check("rfrd_req",  bus.be_req,  1'b1);
        check("rfrd_addr", bus.be_addr, 16'h0043);
        bus.be_ack   = 1'b1;
        bus.be_rdata = 8'h99;
        tick();
        bus.be_ack = 1'b0;
        settle();
        check("rfrd_di", bus.di, 8'h99);
        bus.mreq_n = 1'b1;
        bus.rd_n   = 1'b1;
        tick();
        check("rfrd_one_req", req_rises - req_mark, 1);

        // Read and write strobed together: treated as a write, sticky error.
        bus.A        = 16'h0100;
        bus.cpu_dout = 8'hA5;
        bus.mreq_n   = 1'b0;
        bus.rd_n     = 1'b0;
        bus.wr_n     = 1'b0;
        settle();
        check("perr_before", bus.protocol_err, 1'b0);
        tick();
        check("perr_we",    bus.be_we,        1'b1);
        check("perr_wdata", bus.be_wdata,     8'hA5);
        check("perr_set",   bus.protocol_err, 1'b1);
        bus.be_ack   = 1'b1;
        bus.be_rdata = 8'h11;
        tick();
        bus.be_ack = 1'b0;
        settle();
        check("perr_di_open", bus.di, 8'hFF);
        bus.mreq_n = 1'b1;
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b1;
        tick();
        tick();
        check("perr_sticky", bus.protocol_err, 1'b1);

        // Reset during ACCESS, then a stray ack.
        bus.A      = 16'h2000;
        bus.mreq_n = 1'b0;
        bus.rd_n   = 1'b0;
        tick();
        check("rstmid_req", bus.be_req, 1'b1);
        reset      = 1'b1;
        bus.mreq_n = 1'b1;
        bus.rd_n   = 1'b1;
        tick();
        check("rstmid_req_drop", bus.be_req,       1'b0);
        check("rstmid_wait",     bus.wait_n,       1'b1);
        check("rstmid_di",       bus.di,           8'hFF);
        check("rstmid_perr_clr", bus.protocol_err, 1'b0);
        reset    = 1'b0;
        req_mark = req_rises;
        bus.be_ack   = 1'b1;
        bus.be_rdata = 8'hEE;
        tick();
        bus.be_ack = 1'b0;
        tick();
        check("stray_req",  bus.be_req, 1'b0);
        check("stray_wait", bus.wait_n, 1'b1);
        check("stray_di",   bus.di,     8'hFF);
        check("stray_no_req", req_rises - req_mark, 0);
        bus.A      = 16'h3000;
        bus.mreq_n = 1'b0;
        bus.rd_n   = 1'b0;
        tick();
        check("post_req",  bus.be_req,  1'b1);
        check("post_addr", bus.be_addr, 16'h3000);
        bus.be_ack   = 1'b1;
        bus.be_rdata = 8'h77;
        tick();
        bus.be_ack = 1'b0;
        settle();
        check("post_di", bus.di, 8'h77);
        bus.mreq_n = 1'b1;
        bus.rd_n   = 1'b1;
        tick();
        check("post_di_open", bus.di, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
